// File: rtl/uart_pkg.sv
// Shared 8N1 frame definitions for the UART transmitter/receiver pair.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int   CLKS_PER_BIT = 2501;
   localparam int   DATA_BITS    = 8;
   localparam logic STOP_LEVEL   = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic ff1_q;
   logic ff2_q;

   // Metastability chain; both stages reset to the line's idle level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff1_q <= RESET_VAL;
         ff2_q <= RESET_VAL;
      end else begin
         ff1_q <= d;
         ff2_q <= ff1_q;
      end
   end

   assign q = ff2_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 serial receiver with mid-bit sampling, one-entry holding register,
// valid/ack handshake, framing-error pulse and sticky overrun.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   input  logic       data_ack,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int                 CNT_W     = $clog2(CLKS_PER_BIT);
   localparam int                 HALF_BIT  = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]         IDX_LAST  = 3'(DATA_BITS - 1);

   logic             rx_s;
   uart_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;
   logic             busy_q, busy_d;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // Next-state logic: an acknowledge drains the holding register unless a
   // new byte lands on the same edge, in which case the load wins.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = valid_q & ~data_ack;
      overrun_d   = (data_ack && valid_q) ? 1'b0 : overrun_q;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rx_s == 1'b0) begin
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               idx_d = 3'd0;
               if (rx_s == 1'b0) begin
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               if (idx_q == IDX_LAST) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_s == STOP_LEVEL) begin
                  data_d    = shift_q;
                  valid_d   = 1'b1;
                  overrun_d = data_ack ? 1'b0 : (overrun_q | valid_q);
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // Receiver state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   assign data       = data_q;
   assign data_valid = valid_q;
   assign overrun    = overrun_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial 8N1 receiver: the downstream partner of the transmitter stage on the opposite end of the link.
- Bit period matches the transmitter's divider: 2501 clk cycles per bit, LSB first, idle-high line.
- Recovers bytes from the asynchronous rx line and presents each byte in a one-entry holding register with a valid/ack handshake, plus framing-error and overrun reporting.
- Feeds the board-level consumer (display or loopback back into the transmitter).

Parameters:
- CLKS_PER_BIT, 2501, clk cycles per bit period; must be >= 8.
- HALF_BIT, CLKS_PER_BIT/2 (integer divide), mid-bit sample offset after start-bit detection.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- data  output  8  last correctly framed byte; stable while data_valid=1.
- data_valid  output  1  high from byte load until data_ack.
- data_ack  input  1  consumer accepts data; clears data_valid on the next edge.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- overrun  output  1  sticky; set when a good byte completes while data_valid=1; cleared only by data_ack.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: data=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - Internal: state=IDLE, both synchronizer flops=1, counters=0.
  - Reset asserted mid-frame abandons the frame; no partial byte is ever loaded.
- Input sync: two-flop synchronizer on rx, giving rx_s. All decisions use rx_s only.
- Counters: bit_cnt 0..CLKS_PER_BIT-1 (12 bits at default; width = clog2(CLKS_PER_BIT)); bit_idx 0..7 (3 bits); shift register 8 bits.
- IDLE:
  - rx_s==0 → START, bit_cnt=0.
- START:
  - bit_cnt increments each cycle.
  - When bit_cnt==HALF_BIT-1: if rx_s==0 → DATA, bit_cnt=0, bit_idx=0; otherwise glitch → IDLE, no flags.
- DATA:
  - When bit_cnt==CLKS_PER_BIT-1: shift={rx_s, shift[7:1]} (LSB first), bit_cnt=0.
  - After the sample with bit_idx==7 → STOP; otherwise bit_idx+1.
- STOP:
  - When bit_cnt==CLKS_PER_BIT-1, sample rx_s, then → IDLE the same edge. Returning immediately allows a back-to-back start bit one half-bit later.
  - rx_s==1: data<=shift, data_valid<=1. If data_valid was already 1 and data_ack is not asserted this cycle, overrun<=1 and data is still overwritten with the new byte.
  - rx_s==0: frame_err pulses for 1 cycle; data and data_valid are unchanged.
- Handshake:
  - data_ack while data_valid=1 clears data_valid and overrun on the next edge.
  - Simultaneous data_ack and new-byte load: the load wins (data_valid stays 1, new data) and overrun is not set.
  - data_ack while data_valid=0 is ignored.
- Latency: let T0 be the first edge at which sync flop 1 captures rx=0. data_valid rises on edge T0+2+HALF_BIT+9*CLKS_PER_BIT.
- A break condition (rx held low) yields frame_err once per frame time, then re-enters START while rx stays low.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP}.
  - Default CLKS_PER_BIT=2501, shared with the transmitter.
  - Frame constants: DATA_BITS=8, STOP_LEVEL=1.
- One natural sub-module: uart_sync2, the two-flop synchronizer with parameterised reset value 1, reusable for other asynchronous inputs.

Test Plan (CLKS_PER_BIT=16 unless stated):
- Send 0xA5 with a correct stop bit → data=0xA5, data_valid=1 at edge T0+2+8+144, frame_err never pulses.
- Send 0x3C, then 0x81 back-to-back with no ack → second load sets overrun=1, data=0x81. Pulse data_ack → data_valid=0 and overrun=0 next edge.
- Send 0x55 with stop bit forced 0 → frame_err high for exactly 1 cycle, data_valid stays 0, data keeps its previous value.
- Drive rx low for 5 cycles then high (glitch < HALF_BIT) → returns to IDLE, busy drops, no data_valid, no frame_err.
- Assert rst after bit 4 of 0xF0, release, then send 0x0F → no output from the aborted frame; 0x0F received correctly.
- Default CLKS_PER_BIT=2501: loop the transmitter's Tx into rx, send 0x7E → data=0x7E, data_valid=1, frame_err=0.
